// File: rtl/stepper_pkg.sv
// Shared types and constants for the multi-axis step/direction pulse generator.
// Optional position tracking is enabled by defining STEPPER_POS_EN.
package stepper_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW
    } ch_state_t;

    localparam int PULSE_W_MIN   = 1;
    localparam int SETUP_CYC_MIN = 1;

    // Channel-select width; a single-channel build still carries a 1-bit select.
    function automatic int ch_sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stepper_channel.sv
// One axis channel: move FSM, step/period counters and (with STEPPER_POS_EN) a signed
// position counter updated on every step rising edge.
module stepper_channel
    import stepper_pkg::*;
#(
    parameter int CNT_W     = 32,
    parameter int PER_W     = 32,
    parameter int PULSE_W   = 4,
    parameter int SETUP_CYC = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] steps,
    input  logic [PER_W-1:0] period,
    input  logic             dir,
    input  logic             abort,
    output logic             ready,
    output logic             step_out,
    output logic             dir_out,
    output logic             busy,
    output logic             done
`ifdef STEPPER_POS_EN
    ,
    output logic [CNT_W-1:0] pos
`endif
);

    localparam logic [PER_W:0] PULSE_L = (PER_W+1)'(PULSE_W);
    localparam logic [PER_W:0] SETUP_L = (PER_W+1)'(SETUP_CYC);
    localparam logic [PER_W:0] MIN_PER = (PER_W+1)'(PULSE_W + 1);
    localparam logic [PER_W:0] CYC_ONE = {{PER_W{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    ch_state_t      state_reg;
    logic [CNT_W-1:0] remaining_reg;
    logic [PER_W:0] per_eff_reg;
    logic [PER_W:0] cyc_cnt_reg;
    logic           zero_pend_reg;
    logic           step_reg;
    logic           dir_reg;
    logic           busy_reg;
    logic           done_reg;
    logic           rise_now;
    logic [PER_W:0] period_ext;

    assign period_ext = {1'b0, period};
    // A channel is not ready while a zero-step move or its done pulse is still in flight.
    assign ready    = (state_reg == IDLE) && !zero_pend_reg && !done_reg && !abort;
    assign step_out = step_reg;
    assign dir_out  = dir_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;

    always_comb begin
        rise_now = 1'b0;
        if (!abort) begin
            if ((state_reg == SETUP) && (cyc_cnt_reg == SETUP_L)) begin
                rise_now = 1'b1;
            end else if ((state_reg == LOW) && (cyc_cnt_reg >= per_eff_reg) &&
                         (remaining_reg != '0)) begin
                rise_now = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= IDLE;
            remaining_reg <= '0;
            per_eff_reg   <= '0;
            cyc_cnt_reg   <= '0;
            zero_pend_reg <= 1'b0;
            step_reg      <= 1'b0;
            dir_reg       <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            done_reg      <= zero_pend_reg;
            zero_pend_reg <= 1'b0;
            if (cyc_cnt_reg != '1) begin
                cyc_cnt_reg <= cyc_cnt_reg + CYC_ONE;
            end
            if (abort && (state_reg != IDLE)) begin
                state_reg <= IDLE;
                step_reg  <= 1'b0;
                busy_reg  <= 1'b0;
                done_reg  <= 1'b1;
            end else if (rise_now) begin
                // cyc_cnt counts cycles since this rising edge
                state_reg     <= HIGH;
                step_reg      <= 1'b1;
                cyc_cnt_reg   <= CYC_ONE;
                remaining_reg <= remaining_reg - CNT_ONE;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (start) begin
                            dir_reg       <= dir;
                            remaining_reg <= steps;
                            per_eff_reg   <= (period_ext > MIN_PER) ? period_ext : MIN_PER;
                            cyc_cnt_reg   <= CYC_ONE;
                            if (steps == '0) begin
                                zero_pend_reg <= 1'b1;
                            end else begin
                                state_reg <= SETUP;
                                busy_reg  <= 1'b1;
                            end
                        end
                    end
                    HIGH: begin
                        if (cyc_cnt_reg == PULSE_L) begin
                            step_reg  <= 1'b0;
                            state_reg <= LOW;
                        end
                    end
                    LOW: begin
                        if (cyc_cnt_reg >= per_eff_reg) begin
                            state_reg <= IDLE;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef STEPPER_POS_EN
    logic [CNT_W-1:0] pos_reg;

    assign pos = pos_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            pos_reg <= '0;
        end else if (rise_now) begin
            pos_reg <= dir_reg ? (pos_reg + CNT_ONE) : (pos_reg - CNT_ONE);
        end
    end
`endif

endmodule

// File: rtl/stepper_multi_axis.sv
// N-channel step/direction generator: command demux, ready mux and output packing.
// Defining STEPPER_POS_EN adds the packed per-channel position output.
module stepper_multi_axis
    import stepper_pkg::*;
#(
    parameter int N_CH      = 2,
    parameter int CNT_W     = 32,
    parameter int PER_W     = 32,
    parameter int PULSE_W   = 4,
    parameter int SETUP_CYC = 2,
    localparam int CH_W     = ch_sel_width(N_CH)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [CH_W-1:0]       cmd_ch,
    input  logic [CNT_W-1:0]      cmd_steps,
    input  logic [PER_W-1:0]      cmd_period,
    input  logic                  cmd_dir,
    input  logic [N_CH-1:0]       abort,
    output logic [N_CH-1:0]       step_out,
    output logic [N_CH-1:0]       dir_out,
    output logic [N_CH-1:0]       busy,
    output logic [N_CH-1:0]       done
`ifdef STEPPER_POS_EN
    ,
    output logic [N_CH*CNT_W-1:0] pos
`endif
);

    localparam int PULSE_EFF = (PULSE_W < PULSE_W_MIN) ? PULSE_W_MIN : PULSE_W;
    localparam int SETUP_EFF = (SETUP_CYC < SETUP_CYC_MIN) ? SETUP_CYC_MIN : SETUP_CYC;

    logic [N_CH-1:0] ch_ready;
    logic [N_CH-1:0] ch_start;
    logic            accept;

    // Out-of-range channel selects match no channel and leave cmd_ready low.
    always_comb begin
        cmd_ready = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (int'(cmd_ch) == i) begin
                cmd_ready = ch_ready[i];
            end
        end
    end

    assign accept = cmd_valid && cmd_ready;

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            assign ch_start[gi] = accept && (int'(cmd_ch) == gi);

            stepper_channel #(
                .CNT_W     (CNT_W),
                .PER_W     (PER_W),
                .PULSE_W   (PULSE_EFF),
                .SETUP_CYC (SETUP_EFF)
            ) u_ch (
                .clock    (clock),
                .reset    (reset),
                .start    (ch_start[gi]),
                .steps    (cmd_steps),
                .period   (cmd_period),
                .dir      (cmd_dir),
                .abort    (abort[gi]),
                .ready    (ch_ready[gi]),
                .step_out (step_out[gi]),
                .dir_out  (dir_out[gi]),
                .busy     (busy[gi]),
                .done     (done[gi])
`ifdef STEPPER_POS_EN
                ,
                .pos      (pos[gi*CNT_W +: CNT_W])
`endif
            );
        end
    endgenerate

endmodule

// File: tb/tb_stepper_multi_axis.sv
// Directed self-checking bench for stepper_multi_axis (2 channels, PULSE_W=4, SETUP_CYC=2).
// Position checks are compiled in when STEPPER_POS_EN is defined.
module tb_stepper_multi_axis;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [0:0]  cmd_ch = 1'b0;
    logic [31:0] cmd_steps = '0;
    logic [31:0] cmd_period = '0;
    logic        cmd_dir = 1'b0;
    logic [1:0]  abort = '0;
    logic [1:0]  step_out;
    logic [1:0]  dir_out;
    logic [1:0]  busy;
    logic [1:0]  done;
`ifdef STEPPER_POS_EN
    logic [63:0] pos;
`endif

    int cyc = 0;
    int errors = 0;
    int checks = 0;
    int rise0[$];
    int fall0[$];
    int rise1[$];
    int done0[$];
    int done1[$];
    logic [1:0] prev_step = '0;

    stepper_multi_axis #(
        .N_CH(2), .CNT_W(32), .PER_W(32), .PULSE_W(4), .SETUP_CYC(2)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_ch     (cmd_ch),
        .cmd_steps  (cmd_steps),
        .cmd_period (cmd_period),
        .cmd_dir    (cmd_dir),
        .abort      (abort),
        .step_out   (step_out),
        .dir_out    (dir_out),
        .busy       (busy),
        .done       (done)
`ifdef STEPPER_POS_EN
        ,
        .pos        (pos)
`endif
    );

    always #5 clock = ~clock;

    // cyc holds the index of the most recent rising edge when sampled at a falling edge
    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (step_out[0] && !prev_step[0]) rise0.push_back(cyc);
        if (!step_out[0] && prev_step[0]) fall0.push_back(cyc);
        if (step_out[1] && !prev_step[1]) rise1.push_back(cyc);
        if (done[0]) done0.push_back(cyc);
        if (done[1]) done1.push_back(cyc);
        prev_step <= step_out;
    end

    task automatic clear_log();
        rise0.delete();
        fall0.delete();
        rise1.delete();
        done0.delete();
        done1.delete();
    endtask

    task automatic goto(input int t);
        while (cyc < t) @(negedge clock);
    endtask

    // Called at a falling edge; the command is presented for exactly one rising edge (k).
    task automatic issue(input int ch, input int steps, input int period, input logic dir,
                         output int k, output logic rdy);
        cmd_ch     = 1'(ch);
        cmd_steps  = steps;
        cmd_period = period;
        cmd_dir    = dir;
        cmd_valid  = 1'b1;
        #1;
        rdy = cmd_ready;
        k   = cyc + 1;
        $display("cmd ch=%0d steps=%0d period=%0d dir=%0b ready=%0b edge=%0d",
                 ch, steps, period, dir, rdy, k);
        @(negedge clock);
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if ({step_out, dir_out, busy, done} !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 00", {step_out, dir_out, busy, done});
        end
`ifdef STEPPER_POS_EN
        checks++;
        if (pos !== 64'd0) begin
            errors++;
            $display("FAIL reset_pos: got %h expected 0", pos);
        end
`endif
        reset = 1'b0;
        @(negedge clock);
        cmd_ch = 1'b0;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 1", cmd_ready);
        end
    endtask

    task automatic test_basic();
        int k;
        logic rdy;
        clear_log();
        issue(0, 5, 10, 1'b1, k, rdy);
        checks++;
        if (rdy !== 1'b1) begin errors++; $display("FAIL basic_accept: got %b expected 1", rdy); end
        checks++;
        if ({busy[0], dir_out[0], cmd_ready} !== 3'b110) begin
            errors++;
            $display("FAIL basic_start_state: got %b expected 110", {busy[0], dir_out[0], cmd_ready});
        end
        goto(k + 51);
        checks++;
        if (busy[0] !== 1'b1) begin errors++; $display("FAIL basic_busy_end: got %b expected 1", busy[0]); end
        goto(k + 52);
        checks++;
        if ({done[0], cmd_ready} !== 2'b10) begin
            errors++;
            $display("FAIL basic_done_cycle: got %b expected 10", {done[0], cmd_ready});
        end
        goto(k + 53);
        checks++;
        if ({done[0], busy[0], cmd_ready} !== 3'b001) begin
            errors++;
            $display("FAIL basic_after_done: got %b expected 001", {done[0], busy[0], cmd_ready});
        end
        checks++;
        if (rise0.size() !== 5) begin errors++; $display("FAIL basic_rise_count: got %0d expected 5", rise0.size()); end
        for (int j = 0; j < 5; j++) begin
            int r;
            int f;
            r = (j < rise0.size()) ? rise0[j] : -1;
            f = (j < fall0.size()) ? fall0[j] : -1;
            checks++;
            if (r !== k + 2 + 10 * j) begin
                errors++;
                $display("FAIL basic_rise%0d: got %0d expected %0d", j, r, k + 2 + 10 * j);
            end
            checks++;
            if (f !== k + 6 + 10 * j) begin
                errors++;
                $display("FAIL basic_fall%0d: got %0d expected %0d", j, f, k + 6 + 10 * j);
            end
        end
        checks++;
        if (done0.size() !== 1 || (done0.size() > 0 && done0[0] !== k + 52)) begin
            errors++;
            $display("FAIL basic_done_log: got count %0d first %0d expected 1 at %0d",
                     done0.size(), (done0.size() > 0) ? done0[0] : -1, k + 52);
        end
`ifdef STEPPER_POS_EN
        checks++;
        if (pos[31:0] !== 32'd5) begin errors++; $display("FAIL basic_pos: got %0d expected 5", pos[31:0]); end
`endif
    endtask

    task automatic test_zero_steps();
        int k;
        logic rdy;
        clear_log();
        issue(1, 0, 10, 1'b0, k, rdy);
        checks++;
        if (rdy !== 1'b1) begin errors++; $display("FAIL zero_accept: got %b expected 1", rdy); end
        checks++;
        if ({busy[1], done[1]} !== 2'b00) begin
            errors++;
            $display("FAIL zero_edge_k: got %b expected 00", {busy[1], done[1]});
        end
        goto(k + 1);
        checks++;
        if ({busy[1], done[1]} !== 2'b01) begin
            errors++;
            $display("FAIL zero_done_pulse: got %b expected 01", {busy[1], done[1]});
        end
        goto(k + 2);
        cmd_ch = 1'b1;
        #1;
        checks++;
        if ({done[1], cmd_ready} !== 2'b01) begin
            errors++;
            $display("FAIL zero_after: got %b expected 01", {done[1], cmd_ready});
        end
        goto(k + 12);
        checks++;
        if (rise1.size() !== 0 || done1.size() !== 1) begin
            errors++;
            $display("FAIL zero_log: got rises %0d dones %0d expected 0 and 1", rise1.size(), done1.size());
        end
    endtask

    task automatic test_period_clamp();
        int k;
        logic rdy;
        clear_log();
        issue(0, 3, 2, 1'b1, k, rdy);
        checks++;
        if (rdy !== 1'b1) begin errors++; $display("FAIL clamp_accept: got %b expected 1", rdy); end
        goto(k + 20);
        checks++;
        if (rise0.size() !== 3) begin errors++; $display("FAIL clamp_rise_count: got %0d expected 3", rise0.size()); end
        for (int j = 0; j < 3; j++) begin
            int r;
            r = (j < rise0.size()) ? rise0[j] : -1;
            checks++;
            if (r !== k + 2 + 5 * j) begin
                errors++;
                $display("FAIL clamp_rise%0d: got %0d expected %0d", j, r, k + 2 + 5 * j);
            end
        end
        checks++;
        if (done0.size() !== 1 || (done0.size() > 0 && done0[0] !== k + 17)) begin
            errors++;
            $display("FAIL clamp_done: got count %0d first %0d expected 1 at %0d",
                     done0.size(), (done0.size() > 0) ? done0[0] : -1, k + 17);
        end
    endtask

    task automatic test_back_to_back();
        int k0;
        int k1;
        logic rdy0;
        logic rdy1;
        clear_log();
        issue(0, 10, 8, 1'b1, k0, rdy0);
        issue(1, 3, 20, 1'b0, k1, rdy1);
        checks++;
        if ({rdy0, rdy1} !== 2'b11) begin errors++; $display("FAIL dual_accept: got %b expected 11", {rdy0, rdy1}); end
        goto(k0 + 40);
        cmd_ch = 1'b0;
        #1;
        checks++;
        if ({cmd_ready, busy, dir_out} !== 5'b0_11_01) begin
            errors++;
            $display("FAIL dual_mid: got %b expected 01101", {cmd_ready, busy, dir_out});
        end
        goto(k0 + 82);
        checks++;
        if ({done[0], cmd_ready} !== 2'b10) begin
            errors++;
            $display("FAIL dual_done0_cycle: got %b expected 10", {done[0], cmd_ready});
        end
        goto(k0 + 83);
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL dual_ready_after: got %b expected 1", cmd_ready); end
        goto(k0 + 90);
        checks++;
        if (rise0.size() !== 10 || rise1.size() !== 3) begin
            errors++;
            $display("FAIL dual_counts: got %0d/%0d expected 10/3", rise0.size(), rise1.size());
        end
        for (int j = 0; j < 10; j++) begin
            int r;
            r = (j < rise0.size()) ? rise0[j] : -1;
            checks++;
            if (r !== k0 + 2 + 8 * j) begin
                errors++;
                $display("FAIL dual_rise0_%0d: got %0d expected %0d", j, r, k0 + 2 + 8 * j);
            end
        end
        for (int j = 0; j < 3; j++) begin
            int r;
            r = (j < rise1.size()) ? rise1[j] : -1;
            checks++;
            if (r !== k1 + 2 + 20 * j) begin
                errors++;
                $display("FAIL dual_rise1_%0d: got %0d expected %0d", j, r, k1 + 2 + 20 * j);
            end
        end
        checks++;
        if (done1.size() !== 1 || (done1.size() > 0 && done1[0] !== k1 + 62)) begin
            errors++;
            $display("FAIL dual_done1: got count %0d first %0d expected 1 at %0d",
                     done1.size(), (done1.size() > 0) ? done1[0] : -1, k1 + 62);
        end
    endtask

    task automatic test_abort();
        int k;
        logic rdy;
        clear_log();
        issue(0, 10, 10, 1'b1, k, rdy);
        checks++;
        if (rdy !== 1'b1) begin errors++; $display("FAIL abort_accept: got %b expected 1", rdy); end
        goto(k + 23);
        abort  = 2'b11;
        cmd_ch = 1'b1;
        #1;
        checks++;
        if ({step_out[0], cmd_ready} !== 2'b10) begin
            errors++;
            $display("FAIL abort_wins_ready: got %b expected 10", {step_out[0], cmd_ready});
        end
        goto(k + 24);
        checks++;
        if ({step_out[0], busy[0], done[0], done[1]} !== 4'b0010) begin
            errors++;
            $display("FAIL abort_effect: got %b expected 0010", {step_out[0], busy[0], done[0], done[1]});
        end
        abort = 2'b00;
        goto(k + 25);
        checks++;
        if (done[0] !== 1'b0) begin errors++; $display("FAIL abort_done_width: got %b expected 0", done[0]); end
        goto(k + 60);
        checks++;
        if (rise0.size() !== 3 || done0.size() !== 1 || done1.size() !== 0) begin
            errors++;
            $display("FAIL abort_log: got rises %0d done0 %0d done1 %0d expected 3 1 0",
                     rise0.size(), done0.size(), done1.size());
        end
`ifdef STEPPER_POS_EN
        checks++;
        if (pos !== {32'hFFFF_FFFD, 32'd21}) begin
            errors++;
            $display("FAIL abort_pos: got %h expected fffffffd00000015", pos);
        end
`endif
    endtask

    task automatic test_reset_mid_move();
        int k;
        int k2;
        logic rdy;
        clear_log();
        issue(0, 5, 10, 1'b1, k, rdy);
        goto(k + 13);
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if ({step_out, dir_out, busy, done} !== 8'h00) begin
            errors++;
            $display("FAIL midreset_outputs: got %h expected 00", {step_out, dir_out, busy, done});
        end
`ifdef STEPPER_POS_EN
        checks++;
        if (pos !== 64'd0) begin errors++; $display("FAIL midreset_pos: got %h expected 0", pos); end
`endif
        reset = 1'b0;
        clear_log();
        issue(0, 2, 6, 1'b1, k2, rdy);
        checks++;
        if (rdy !== 1'b1) begin errors++; $display("FAIL midreset_accept: got %b expected 1", rdy); end
        goto(k2 + 20);
        checks++;
        if (rise0.size() !== 2 || (rise0.size() == 2 && (rise0[0] !== k2 + 2 || rise0[1] !== k2 + 8))) begin
            errors++;
            $display("FAIL midreset_rises: got count %0d expected rises at %0d and %0d",
                     rise0.size(), k2 + 2, k2 + 8);
        end
        checks++;
        if (done0.size() !== 1 || (done0.size() > 0 && done0[0] !== k2 + 14)) begin
            errors++;
            $display("FAIL midreset_done: got count %0d first %0d expected 1 at %0d",
                     done0.size(), (done0.size() > 0) ? done0[0] : -1, k2 + 14);
        end
`ifdef STEPPER_POS_EN
        checks++;
        if (pos[31:0] !== 32'd2) begin errors++; $display("FAIL midreset_pos_after: got %0d expected 2", pos[31:0]); end
`endif
    endtask

    initial begin
        @(negedge clock);
        test_reset();
        test_basic();
        test_zero_steps();
        test_period_clamp();
        test_back_to_back();
        test_abort();
        test_reset_mid_move();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
